seg7_decoder: RTL

Decodes a multiplexed, active-low 7-segment display drive back into packed BCD digits. It sits on the display side of the lab designs as a monitor/loopback checker: it samples the segment bus and digit-select lines that feed the board's HEX displays, and waits for each digit's pattern to be stable before capturing it. It then reports the decoded value, a per-digit invalid-pattern flag and a frame-complete pulse.

---
 rtl/seg7_decoder.sv | 124 ++++++++++++
 1 files changed

// File: rtl/seg7_decoder.sv
// Loopback monitor for a multiplexed active-low 7-segment bus: waits for each
// digit pattern to settle, decodes it to BCD and flags frame completion.
module seg7_decoder #(
  parameter int NDIG   = 4,
  parameter int STABLE = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [6:0]        leds,
  input  logic [NDIG-1:0]   digit_sel,
  output logic [4*NDIG-1:0] bcd_out,
  output logic [NDIG-1:0]   digit_err,
  output logic              frame_valid,
  output logic              sel_err
);
  // state  | meaning
  // IDLE   | sampled sel is blank or not one-hot
  // SETTLE | counting identical samples of a one-hot pair
  // HELD   | pair already captured, waiting for the next change
  typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;

  localparam int            CW       = $clog2(STABLE + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE - 1);

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [NDIG-1:0]   sel_q, sel_prev_q;
  logic [6:0]        leds_q, leds_prev_q;
  logic [NDIG-1:0]   seen_q, seen_d;
  logic [4*NDIG-1:0] bcd_q;
  logic [NDIG-1:0]   err_q;
  logic              fv_q, se_q;
  logic              changed, sel_onehot, sel_bad, capture, frame_done;
  logic [3:0]        dec_val;
  logic              dec_ok;

  always_comb begin
    dec_ok  = 1'b1;
    dec_val = 4'd0;
    case (leds_q)
      7'b1000000: dec_val = 4'd0;
      7'b1111001: dec_val = 4'd1;
      7'b0100100: dec_val = 4'd2;
      7'b0110000: dec_val = 4'd3;
      7'b0011001: dec_val = 4'd4;
      7'b0010010: dec_val = 4'd5;
      7'b0000010: dec_val = 4'd6;
      7'b1111000: dec_val = 4'd7;
      7'b0000000: dec_val = 4'd8;
      7'b0010000: dec_val = 4'd9;
      default:    dec_ok  = 1'b0;
    endcase
  end

  // The change edge itself counts as the first identical sample.
  always_comb begin
    changed    = (sel_q != sel_prev_q) || (leds_q != leds_prev_q);
    sel_onehot = $onehot(sel_q);
    sel_bad    = (sel_q != '0) && !sel_onehot;
    state_d    = state_q;
    cnt_d      = cnt_q;
    capture    = 1'b0;
    if (changed) begin
      if (!sel_onehot) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else if (STABLE == 1) begin
        capture = 1'b1;
        state_d = HELD;
        cnt_d   = CW'(1);
      end else begin
        state_d = SETTLE;
        cnt_d   = CW'(1);
      end
    end else if (state_q == SETTLE) begin
      if (cnt_q == CNT_LAST) begin
        capture = 1'b1;
        state_d = HELD;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    seen_d     = seen_q | (capture ? sel_q : '0);
    frame_done = capture && (&seen_d);
    if (frame_done) seen_d = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel_q       <= '0;
      leds_q      <= 7'h7F;
      sel_prev_q  <= '0;
      leds_prev_q <= 7'h7F;
      state_q     <= IDLE;
      cnt_q       <= '0;
      seen_q      <= '0;
      bcd_q       <= '0;
      err_q       <= '0;
      fv_q        <= 1'b0;
      se_q        <= 1'b0;
    end else begin
      sel_q       <= digit_sel;
      leds_q      <= leds;
      sel_prev_q  <= sel_q;
      leds_prev_q <= leds_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      seen_q      <= seen_d;
      fv_q        <= frame_done;
      se_q        <= (sel_q != sel_prev_q) && sel_bad;
      for (int i = 0; i < NDIG; i++) begin
        if (capture && sel_q[i]) begin
          if (dec_ok) bcd_q[4*i +: 4] <= dec_val;
          err_q[i] <= !dec_ok;
        end
      end
    end
  end

  assign bcd_out     = bcd_q;
  assign digit_err   = err_q;
  assign frame_valid = fv_q;
  assign sel_err     = se_q;
endmodule
